// File: rtl/gated_d_latch_if.sv
// gated_d_latch_if: data-in / data-out bundle of a gated D latch.
interface gated_d_latch_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qn;
    modport master (output D, input Q, input Qn);
    modport slave (input D, output Q, output Qn);
endinterface

// File: rtl/gated_d_latch.sv
// gated_d_latch: level-sensitive D latch, transparent while clk is high, with reset qualified by clk.
module gated_d_latch #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic clk,
    input logic rst,
    gated_d_latch_if.slave bus
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    assign q_d = rst ? RESET_VALUE : bus.D;
    // The only storage loop; rst and D are ignored while the gate is low.
    always_latch begin
        if (clk) q_q <= q_d;
    end
    assign bus.Q = q_q;
    assign bus.Qn = ~q_q;
endmodule

// File: tb/tb_gated_d_latch.sv
// tb_gated_d_latch: directed checks of a 1-bit latch, an 8-bit latch with non-zero reset, and a master-slave pair.
module tb_gated_d_latch;
    int checks = 0;
    int errors = 0;
    logic c0, r0, c8, r8, mc, mcn;
    gated_d_latch_if #(.WIDTH(1)) if0 ();
    gated_d_latch_if #(.WIDTH(8)) if8 ();
    gated_d_latch_if #(.WIDTH(1)) ifm ();
    gated_d_latch_if #(.WIDTH(1)) ifs ();
    gated_d_latch #(.WIDTH(1)) u0 (.clk(c0), .rst(r0), .bus(if0.slave));
    gated_d_latch #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (.clk(c8), .rst(r8), .bus(if8.slave));
    gated_d_latch #(.WIDTH(1)) um (.clk(mcn), .rst(1'b0), .bus(ifm.slave));
    gated_d_latch #(.WIDTH(1)) us (.clk(mc), .rst(1'b0), .bus(ifs.slave));
    assign mcn = ~mc;
    assign ifs.D = ifm.Q;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask
    initial begin
        c0 = 0; r0 = 0; if0.D = 0;
        c8 = 0; r8 = 0; if8.D = 8'h00;
        mc = 0; ifm.D = 0;
        #10 c0 = 1;
        #1 chk("pwrup_first_high", 8'(if0.Q), 8'h00);
        #9 if0.D = 1;
        #1 chk("track_1", 8'(if0.Q), 8'h01);
        chk("track_1_qn", 8'(if0.Qn), 8'h00);
        #9 if0.D = 0;
        #1 chk("track_0", 8'(if0.Q), 8'h00);
        chk("track_0_qn", 8'(if0.Qn), 8'h01);
        #9 if0.D = 1;
        #10 c0 = 0;
        #10 if0.D = 0;
        #1 chk("hold_d0", 8'(if0.Q), 8'h01);
        for (int i = 0; i < 3; i++) begin
            #9 if0.D = ~if0.D;
            #1 chk("hold_toggle", 8'(if0.Q), 8'h01);
            chk("hold_toggle_qn", 8'(if0.Qn), 8'h00);
        end
        #9 r0 = 1;
        #1 chk("rst_clk_low", 8'(if0.Q), 8'h01);
        #9 c0 = 1;
        #1 chk("rst_clk_high", 8'(if0.Q), 8'h00);
        chk("rst_clk_high_qn", 8'(if0.Qn), 8'h01);
        #9 r0 = 0;
        #1 chk("rst_release", 8'(if0.Q), 8'h01);
        #9 c8 = 1; if8.D = 8'h3C;
        #1 chk("w8_track", if8.Q, 8'h3C);
        chk("w8_track_qn", if8.Qn, 8'hC3);
        #9 r8 = 1;
        #1 chk("w8_rst", if8.Q, 8'hA5);
        chk("w8_rst_qn", if8.Qn, 8'h5A);
        #9 c8 = 0;
        #10 r8 = 0; if8.D = 8'hFF;
        #1 chk("w8_hold", if8.Q, 8'hA5);
        #9 mc = 1;
        #10 mc = 0;
        #10 chk("ms_d0", 8'(ifs.Q), 8'h00);
        ifm.D = 1;
        #10 chk("ms_d1_clk_low", 8'(ifs.Q), 8'h00);
        mc = 1;
        #1 chk("ms_rise", 8'(ifs.Q), 8'h01);
        #9 mc = 0;
        #10 chk("ms_fall_hold", 8'(ifs.Q), 8'h01);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
